// File: rtl/rs_slot_alloc.sv
// Reservation-station slot allocator: busy bitmap, lowest-free grant, single release, flush.
// Optional macro RS_SLOT_ALLOC_DBL_FREE_CHK_EN builds the sticky double-free detector.

module leading_zero_one_cnt #(
  parameter int WIDTH      = 16,
  parameter bit COUNT_ZERO = 1'b1
) (
  input  logic [WIDTH-1:0]       data,
  output logic [$clog2(WIDTH):0] cnt
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic STOP_BIT = COUNT_ZERO ? 1'b1 : 1'b0;

  // Counts matching bits upward from bit 0; WIDTH (MSB set) when every bit matches.
  always_comb begin
    cnt = CNT_W'(WIDTH);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (data[i] == STOP_BIT) cnt = CNT_W'(i);
    end
  end
endmodule

module rs_slot_alloc #(
  parameter int NUM_ENTRY = 16,
  localparam int IDX_W = $clog2(NUM_ENTRY)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_req,
  output logic             alloc_gnt,
  output logic [IDX_W-1:0] alloc_idx,
  input  logic             free_valid,
  input  logic [IDX_W-1:0] free_idx,
  input  logic             flush,
  output logic [IDX_W:0]   free_cnt,
  output logic             full,
  output logic             dbl_free_err
);
  logic [NUM_ENTRY-1:0] busy;
  logic [NUM_ENTRY-1:0] busy_nxt;
  logic [NUM_ENTRY-1:0] free_mask;
  logic [IDX_W:0]       search_cnt;
  logic [IDX_W:0]       free_cnt_nxt;
  logic                 release_ok;

  assign free_mask = ~busy;

  leading_zero_one_cnt #(
    .WIDTH      (NUM_ENTRY),
    .COUNT_ZERO (1'b1)
  ) u_search (
    .data (free_mask),
    .cnt  (search_cnt)
  );

  assign alloc_idx  = full ? '0 : search_cnt[IDX_W-1:0];
  assign alloc_gnt  = alloc_req & ~full & ~flush & ~rst;
  // A slot free at cycle start (including the one being granted) cannot be released.
  assign release_ok = free_valid & busy[free_idx];

  always_comb begin
    busy_nxt = busy;
    if (alloc_gnt)  busy_nxt[alloc_idx] = 1'b1;
    if (release_ok) busy_nxt[free_idx]  = 1'b0;
    free_cnt_nxt = free_cnt - {{IDX_W{1'b0}}, alloc_gnt} + {{IDX_W{1'b0}}, release_ok};
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      busy     <= '0;
      free_cnt <= (IDX_W+1)'(NUM_ENTRY);
      full     <= 1'b0;
    end else begin
      busy     <= busy_nxt;
      free_cnt <= free_cnt_nxt;
      full     <= (free_cnt_nxt == '0);
    end
  end

`ifdef RS_SLOT_ALLOC_DBL_FREE_CHK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      dbl_free_err <= 1'b0;
    end else if (!flush && free_valid && !busy[free_idx]) begin
      dbl_free_err <= 1'b1;
    end
  end
`else
  assign dbl_free_err = 1'b0;
`endif
endmodule

// File: tb/tb_rs_slot_alloc.sv
// Self-checking bench for rs_slot_alloc: directed scenarios plus randomized traffic
// checked against a bitmap-level reference model.

module tb_rs_slot_alloc;
  localparam int N = 16;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          alloc_req;
  logic          alloc_gnt;
  logic [IW-1:0] alloc_idx;
  logic          free_valid;
  logic [IW-1:0] free_idx;
  logic          flush;
  logic [IW:0]   free_cnt;
  logic          full;
  logic          dbl_free_err;

  int total = 0;
  int bad   = 0;

  // Reference model state: plain occupancy bitmap and sticky error.
  logic [N-1:0] m_busy;
  logic         m_err;

  rs_slot_alloc #(.NUM_ENTRY(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .alloc_req    (alloc_req),
    .alloc_gnt    (alloc_gnt),
    .alloc_idx    (alloc_idx),
    .free_valid   (free_valid),
    .free_idx     (free_idx),
    .flush        (flush),
    .free_cnt     (free_cnt),
    .full         (full),
    .dbl_free_err (dbl_free_err)
  );

  always #5 clk = ~clk;

  function automatic int lowest_free(input logic [N-1:0] b);
    for (int i = 0; i < N; i++) if (!b[i]) return i;
    return N;
  endfunction

  function automatic int free_count(input logic [N-1:0] b);
    int c = 0;
    for (int i = 0; i < N; i++) if (!b[i]) c++;
    return c;
  endfunction

  // Drive inputs shortly after the rising edge and let them settle.
  task automatic apply(input logic r, input logic req, input logic fv,
                       input int fi, input logic fl);
    rst        = r;
    alloc_req  = req;
    free_valid = fv;
    free_idx   = IW'(fi);
    flush      = fl;
    #1;
  endtask

  // Update the model from the applied inputs, then cross the next rising edge.
  task automatic advance();
    int  lf;
    bit  g;
    bit  v;
    lf = lowest_free(m_busy);
    if (rst) begin
      m_busy = '0;
      m_err  = 1'b0;
    end else if (flush) begin
      m_busy = '0;
    end else begin
      g = alloc_req && (lf < N);
      v = free_valid && m_busy[free_idx];
`ifdef RS_SLOT_ALLOC_DBL_FREE_CHK_EN
      if (free_valid && !v) m_err = 1'b1;
`endif
      if (g) m_busy[lf] = 1'b1;
      if (v) m_busy[free_idx] = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply(1, 0, 0, 0, 0);
    advance();
    advance();
    apply(0, 0, 0, 0, 0);
    total++; if (free_cnt !== 5'(N)) begin bad++; $display("FAIL reset_free_cnt got=%0d exp=%0d", free_cnt, N); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
    total++; if (alloc_idx !== 4'd0) begin bad++; $display("FAIL reset_alloc_idx got=%0d exp=0", alloc_idx); end
    total++; if (alloc_gnt !== 1'b0) begin bad++; $display("FAIL reset_alloc_gnt got=%b exp=0", alloc_gnt); end
    total++; if (dbl_free_err !== 1'b0) begin bad++; $display("FAIL reset_dbl_err got=%b exp=0", dbl_free_err); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < N; i++) begin
      apply(0, 1, 0, 0, 0);
      total++; if (alloc_gnt !== 1'b1) begin bad++; $display("FAIL fill_gnt[%0d] got=%b exp=1", i, alloc_gnt); end
      total++; if (alloc_idx !== 4'(i)) begin bad++; $display("FAIL fill_idx[%0d] got=%0d exp=%0d", i, alloc_idx, i); end
      total++; if (free_cnt !== 5'(N - i)) begin bad++; $display("FAIL fill_cnt[%0d] got=%0d exp=%0d", i, free_cnt, N - i); end
      advance();
    end
    apply(0, 1, 0, 0, 0);
    total++; if (full !== 1'b1) begin bad++; $display("FAIL fill_full got=%b exp=1", full); end
    total++; if (free_cnt !== 5'd0) begin bad++; $display("FAIL fill_cnt_end got=%0d exp=0", free_cnt); end
    total++; if (alloc_gnt !== 1'b0) begin bad++; $display("FAIL fill_17th_gnt got=%b exp=0", alloc_gnt); end
    total++; if (alloc_idx !== 4'd0) begin bad++; $display("FAIL fill_17th_idx got=%0d exp=0", alloc_idx); end
    advance();
  endtask

  task automatic test_release_order();
    apply(0, 0, 1, 5, 0);
    total++; if (free_cnt !== 5'd0) begin bad++; $display("FAIL rel_cnt0 got=%0d exp=0", free_cnt); end
    advance();
    apply(0, 0, 1, 2, 0);
    total++; if (free_cnt !== 5'd1) begin bad++; $display("FAIL rel_cnt1 got=%0d exp=1", free_cnt); end
    total++; if (alloc_idx !== 4'd5) begin bad++; $display("FAIL rel_idx_after5 got=%0d exp=5", alloc_idx); end
    advance();
    apply(0, 1, 0, 0, 0);
    total++; if (free_cnt !== 5'd2) begin bad++; $display("FAIL rel_cnt2 got=%0d exp=2", free_cnt); end
    total++; if (alloc_gnt !== 1'b1 || alloc_idx !== 4'd2) begin bad++; $display("FAIL rel_first_grant got=%b/%0d exp=1/2", alloc_gnt, alloc_idx); end
    advance();
    apply(0, 1, 0, 0, 0);
    total++; if (free_cnt !== 5'd1) begin bad++; $display("FAIL rel_cnt3 got=%0d exp=1", free_cnt); end
    total++; if (alloc_gnt !== 1'b1 || alloc_idx !== 4'd5) begin bad++; $display("FAIL rel_second_grant got=%b/%0d exp=1/5", alloc_gnt, alloc_idx); end
    advance();
    apply(0, 0, 0, 0, 0);
    total++; if (free_cnt !== 5'd0 || full !== 1'b1) begin bad++; $display("FAIL rel_end got=%0d/%b exp=0/1", free_cnt, full); end
  endtask

  task automatic test_flush();
    apply(0, 1, 1, 7, 1);
    total++; if (alloc_gnt !== 1'b0) begin bad++; $display("FAIL flush_gnt got=%b exp=0", alloc_gnt); end
    advance();
    apply(0, 0, 0, 0, 0);
    total++; if (free_cnt !== 5'(N) || full !== 1'b0 || alloc_idx !== 4'd0) begin
      bad++; $display("FAIL flush_state got=cnt%0d full%b idx%0d exp=cnt16 full0 idx0", free_cnt, full, alloc_idx);
    end
  endtask

  task automatic test_same_cycle();
    for (int i = 0; i < 8; i++) begin apply(0, 1, 0, 0, 0); advance(); end
    apply(0, 1, 1, 3, 0);
    total++; if (alloc_gnt !== 1'b1 || alloc_idx !== 4'd8) begin bad++; $display("FAIL same_grant got=%b/%0d exp=1/8", alloc_gnt, alloc_idx); end
    advance();
    apply(0, 0, 0, 0, 0);
    total++; if (free_cnt !== 5'd8) begin bad++; $display("FAIL same_cnt got=%0d exp=8", free_cnt); end
    total++; if (alloc_idx !== 4'd3) begin bad++; $display("FAIL same_next_idx got=%0d exp=3", alloc_idx); end
    apply(0, 1, 0, 0, 0);
    advance();
    apply(0, 1, 0, 0, 0);
    total++; if (alloc_idx !== 4'd9) begin bad++; $display("FAIL same_after_idx got=%0d exp=9", alloc_idx); end
    apply(1, 0, 0, 0, 0);
    advance();
  endtask

  task automatic test_double_free();
    logic exp_err;
`ifdef RS_SLOT_ALLOC_DBL_FREE_CHK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    for (int i = 0; i < 4; i++) begin apply(0, 1, 0, 0, 0); advance(); end
    apply(0, 0, 1, 9, 0);
    total++; if (dbl_free_err !== 1'b0) begin bad++; $display("FAIL dbl_pre got=%b exp=0", dbl_free_err); end
    advance();
    apply(0, 0, 0, 0, 0);
    total++; if (dbl_free_err !== exp_err) begin bad++; $display("FAIL dbl_set got=%b exp=%b", dbl_free_err, exp_err); end
    total++; if (free_cnt !== 5'd12 || alloc_idx !== 4'd4) begin bad++; $display("FAIL dbl_state got=cnt%0d idx%0d exp=cnt12 idx4", free_cnt, alloc_idx); end
    apply(0, 0, 0, 0, 1);
    advance();
    apply(0, 0, 0, 0, 0);
    total++; if (dbl_free_err !== exp_err) begin bad++; $display("FAIL dbl_after_flush got=%b exp=%b", dbl_free_err, exp_err); end
    apply(1, 0, 0, 0, 0);
    advance();
    apply(0, 0, 0, 0, 0);
    total++; if (dbl_free_err !== 1'b0) begin bad++; $display("FAIL dbl_after_rst got=%b exp=0", dbl_free_err); end
    // Releasing the very slot being granted: grant proceeds, release is a double free.
    apply(0, 1, 1, 0, 0);
    total++; if (alloc_gnt !== 1'b1 || alloc_idx !== 4'd0) begin bad++; $display("FAIL dbl_same_grant got=%b/%0d exp=1/0", alloc_gnt, alloc_idx); end
    advance();
    apply(0, 0, 0, 0, 0);
    total++; if (free_cnt !== 5'd15 || alloc_idx !== 4'd1 || dbl_free_err !== exp_err) begin
      bad++; $display("FAIL dbl_same_state got=cnt%0d idx%0d err%b exp=cnt15 idx1 err%b", free_cnt, alloc_idx, dbl_free_err, exp_err);
    end
    apply(1, 0, 0, 0, 0);
    advance();
  endtask

  task automatic test_random();
    int lf;
    int fi;
    for (int c = 0; c < 10000; c++) begin
      fi = $urandom_range(N - 1, 0);
      apply(($urandom_range(999, 0) < 3) ? 1'b1 : 1'b0,
            ($urandom_range(99, 0) < 60) ? 1'b1 : 1'b0,
            ($urandom_range(99, 0) < 45) ? 1'b1 : 1'b0,
            fi,
            ($urandom_range(999, 0) < 15) ? 1'b1 : 1'b0);
      lf = lowest_free(m_busy);
      total++; if (free_cnt !== 5'(free_count(m_busy))) begin bad++; $display("FAIL rnd_cnt c=%0d got=%0d exp=%0d", c, free_cnt, free_count(m_busy)); end
      total++; if (full !== (lf == N)) begin bad++; $display("FAIL rnd_full c=%0d got=%b exp=%b", c, full, lf == N); end
      total++; if (alloc_idx !== ((lf == N) ? 4'd0 : 4'(lf))) begin bad++; $display("FAIL rnd_idx c=%0d got=%0d exp=%0d", c, alloc_idx, (lf == N) ? 0 : lf); end
      total++; if (alloc_gnt !== (alloc_req && !rst && !flush && lf < N)) begin
        bad++; $display("FAIL rnd_gnt c=%0d got=%b exp=%b", c, alloc_gnt, alloc_req && !rst && !flush && lf < N);
      end
      total++; if (dbl_free_err !== m_err) begin bad++; $display("FAIL rnd_err c=%0d got=%b exp=%b", c, dbl_free_err, m_err); end
      advance();
    end
  endtask

  initial begin
    m_busy = '0;
    m_err  = 1'b0;
    apply(1, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    test_reset();
    test_fill();
    test_release_order();
    apply(1, 0, 0, 0, 0);
    advance();
    test_fill();
    test_flush();
    test_same_cycle();
    test_double_free();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
